demux_stream_router: RTL and testbench

- Parametrised, registered successor of the 4-way demultiplexer.
- Routes a valid/ready input word stream to one of NUM_CH output channels, selected per word, or to all enabled channels in broadcast mode.
- Each channel has a one-deep output register with its own valid/ready handshake, so channels drain independently.
- Sits between a single producer and NUM_CH consumers. Words addressed to disabled or nonexistent channels are dropped and counted.

---
 rtl/demux_stream_router.sv | 67 ++++++
 tb/tb_demux_stream_router.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_router.sv
// rtl/demux_stream_router.sv - registered valid/ready demultiplexer with one-deep output slot per channel
// Unicast or all-enabled broadcast; words with no live target are dropped and counted.
module demux_stream_router #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  input  logic [NUM_CH-1:0]        ch_enable,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         drop_count
);

  logic [NUM_CH-1:0] target;
  logic [NUM_CH-1:0] slot_free;
  logic [NUM_CH-1:0] load;
  logic              accept;

  // An out-of-range in_sel matches no channel, so it falls through to the drop path.
  always_comb begin
    target = '0;
    if (in_bcast) begin
      target = ch_enable;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_sel == SEL_W'(i)) target[i] = ch_enable[i];
      end
    end
  end

  assign slot_free = ~out_valid | out_ready;
  assign in_ready  = &(slot_free | ~target);
  assign accept    = in_valid & in_ready;
  assign load      = target & {NUM_CH{accept}};

  // Refill wins over drain so a busy channel sustains one word per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= '0;
      out_data   <= '0;
      drop_count <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load[i]) begin
          out_valid[i]                  <= 1'b1;
          out_data[i*DATA_W +: DATA_W]  <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i]                  <= 1'b0;
          out_data[i*DATA_W +: DATA_W]  <= '0;
        end
      end
      if (accept && (target == '0) && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_stream_router.sv
// tb/tb_demux_stream_router.sv - self-checking bench for demux_stream_router
// Directed vector table, saturation sequence, then random traffic against a slot model.
module tb_demux_stream_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic [3:0]  ch_enable;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [7:0]  drop_count;

  logic        s_in_ready;
  logic [3:0]  s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_drop_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux_stream_router #(.DATA_W(8), .NUM_CH(4), .SEL_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast), .ch_enable(ch_enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_count(drop_count)
  );

  demux_stream_router #(.DATA_W(8), .NUM_CH(4), .SEL_W(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast), .ch_enable(ch_enable),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .drop_count(s_drop_count)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic [1:0]  sel;
    logic        bc;
    logic [3:0]  en;
    logic [3:0]  ordy;
    logic        ir;
    logic [3:0]  ov;
    logic [31:0] od;
    logic [7:0]  dc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic [1:0] s,
                       input logic b, input logic [3:0] e, input logic [3:0] o);
    rst = r; in_valid = v; in_data = d; in_sel = s; in_bcast = b; ch_enable = e; out_ready = o;
  endtask

  function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic [1:0] s, logic b,
                              logic [3:0] e, logic [3:0] o, logic ir, logic [3:0] ov,
                              logic [31:0] od, logic [7:0] dc);
    vec_t x;
    x.rst = r; x.v = v; x.d = d; x.sel = s; x.bc = b; x.en = e; x.ordy = o;
    x.ir = ir; x.ov = ov; x.od = od; x.dc = dc;
    return x;
  endfunction

  // Reference model: four slots as plain arrays plus a total drop tally.
  bit         m_valid[4];
  logic [7:0] m_data[4];
  int         m_drops;

  function automatic logic [31:0] m_out_data();
    logic [31:0] r = '0;
    for (int c = 0; c < 4; c++) if (m_valid[c]) r[c*8 +: 8] = m_data[c];
    return r;
  endfunction

  function automatic logic [3:0] m_out_valid();
    logic [3:0] r = '0;
    for (int c = 0; c < 4; c++) r[c] = m_valid[c];
    return r;
  endfunction

  initial begin
    int          k;
    bit          tset[4];
    bit          tempty;
    bit          exp_ready;
    logic [31:0] rnd;

    drive(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'hF);
    @(posedge clk); #1;

    //       rst v  data  sel bc en    ordy  | ir ov     od            dc
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'hF, 4'hF, 1, 4'h0, 32'h00000000, 0));
    tbl.push_back(mk(0, 1, 8'hA5, 2, 0, 4'hF, 4'hF, 1, 4'h4, 32'h00A50000, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'hF, 4'hF, 1, 4'h0, 32'h00000000, 0));
    tbl.push_back(mk(0, 1, 8'h11, 1, 0, 4'hF, 4'hD, 1, 4'h2, 32'h00001100, 0));
    tbl.push_back(mk(0, 1, 8'h22, 1, 0, 4'hF, 4'hD, 0, 4'h2, 32'h00001100, 0));
    tbl.push_back(mk(0, 1, 8'h22, 1, 0, 4'hF, 4'hF, 1, 4'h2, 32'h00002200, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'hF, 4'hF, 1, 4'h0, 32'h00000000, 0));
    tbl.push_back(mk(0, 1, 8'h77, 3, 0, 4'hF, 4'h7, 1, 4'h8, 32'h77000000, 0));
    tbl.push_back(mk(0, 1, 8'h3C, 0, 1, 4'hB, 4'h7, 0, 4'h8, 32'h77000000, 0));
    tbl.push_back(mk(0, 1, 8'h3C, 0, 1, 4'hB, 4'hF, 1, 4'hB, 32'h3C003C3C, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'hF, 4'hF, 1, 4'h0, 32'h00000000, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 0, 4'hE, 4'hF, 1, 4'h0, 32'h00000000, 1));
    tbl.push_back(mk(0, 1, 8'h02, 0, 0, 4'hE, 4'hF, 1, 4'h0, 32'h00000000, 2));
    tbl.push_back(mk(0, 1, 8'h03, 0, 0, 4'hE, 4'hF, 1, 4'h0, 32'h00000000, 3));
    tbl.push_back(mk(0, 1, 8'h04, 0, 1, 4'h0, 4'hF, 1, 4'h0, 32'h00000000, 4));
    tbl.push_back(mk(0, 1, 8'h5A, 0, 1, 4'hF, 4'h0, 1, 4'hF, 32'h5A5A5A5A, 4));
    tbl.push_back(mk(1, 1, 8'h99, 0, 1, 4'hF, 4'h0, 0, 4'h0, 32'h00000000, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'hF, 4'h0, 1, 4'h0, 32'h00000000, 0));
    tbl.push_back(mk(1, 1, 8'h66, 0, 0, 4'hF, 4'h0, 1, 4'h0, 32'h00000000, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'hF, 4'h0, 1, 4'h0, 32'h00000000, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].sel, tbl[i].bc, tbl[i].en, tbl[i].ordy);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(tbl[i].od));
      chk($sformatf("vec%0d_drop_count", i), 64'(drop_count), 64'(tbl[i].dc));
      chk($sformatf("vec%0d_sat_drop", i), 64'(s_drop_count),
          64'((tbl[i].dc > 8'd3) ? 8'd3 : tbl[i].dc));
    end

    // Six drops: the 2-bit counter must stop at 3 while the 8-bit one keeps going.
    for (int n = 1; n <= 6; n++) begin
      drive(1'b0, 1'b1, 8'(n), 2'd0, 1'b0, 4'hE, 4'hF);
      #1;
      chk("sat_in_ready", 64'(s_in_ready), 64'(1));
      @(posedge clk); #1;
      chk("sat_drop_count", 64'(s_drop_count), 64'((n > 3) ? 3 : n));
      chk("wide_drop_count", 64'(drop_count), 64'(n));
      chk("sat_out_valid", 64'(s_out_valid), 64'(0));
    end

    // Random traffic; first cycle is a reset so model and DUT start aligned.
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom;
      drive((n == 0) || ($urandom_range(39) == 0), ($urandom_range(3) != 0), 8'(rnd),
            2'(rnd >> 8), ($urandom_range(5) == 0),
            4'(rnd >> 12) | 4'(rnd >> 16), 4'(rnd >> 20));
      #1;
      tempty = 1'b1;
      for (int c = 0; c < 4; c++) begin
        tset[c] = in_bcast ? ch_enable[c] : ((int'(in_sel) == c) && ch_enable[c]);
        if (tset[c]) tempty = 1'b0;
      end
      exp_ready = 1'b1;
      for (int c = 0; c < 4; c++) if (tset[c] && m_valid[c] && !out_ready[c]) exp_ready = 1'b0;
      if (n != 0) chk("rnd_in_ready", 64'(in_ready), 64'(exp_ready));

      if (rst) begin
        for (int c = 0; c < 4; c++) begin m_valid[c] = 1'b0; m_data[c] = '0; end
        m_drops = 0;
      end else begin
        for (int c = 0; c < 4; c++) begin
          if (in_valid && exp_ready && tset[c]) begin
            m_valid[c] = 1'b1;
            m_data[c]  = in_data;
          end else if (m_valid[c] && out_ready[c]) begin
            m_valid[c] = 1'b0;
          end
        end
        if (in_valid && exp_ready && tempty) m_drops++;
      end

      @(posedge clk); #1;
      chk("rnd_out_valid", 64'(out_valid), 64'(m_out_valid()));
      chk("rnd_out_data", 64'(out_data), 64'(m_out_data()));
      chk("rnd_drop_count", 64'(drop_count), 64'((m_drops > 255) ? 255 : m_drops));
      chk("rnd_sat_drop", 64'(s_drop_count), 64'((m_drops > 3) ? 3 : m_drops));
    end

    k = total;
    $display("test done: total=%0d bad=%0d", k, bad);
    $finish;
  end

endmodule
